// File: rtl/ifu_pkg.sv
// ifu_pkg: definitions shared by the instruction-fetch stage.
//   fetch_state_e     fetch FSM state (2-bit encoding)
//   RESET_PC_DEFAULT  PC loaded on reset
//   INST_W_DEFAULT    instruction width
//   PC_STEP           sequential PC increment in bytes
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam int          INST_W_DEFAULT   = 32;
    localparam int          PC_STEP          = 4;

endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter register.
//   clk, rst   clock, asynchronous active-high reset (loads RESET_PC)
//   load_en    load load_pc (low two bits forced to zero); wins over inc_en
//   load_pc    redirect target
//   inc_en     advance by PC_STEP, wrapping modulo 2^ADDR_W
//   pc         current PC
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = {load_pc[ADDR_W-1:2], 2'b00};
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage feeding the decoder.
//   clk, rst                      clock, asynchronous active-high reset
//   redirect_valid, redirect_pc   next-PC redirect from the branch/jump mux
//   imem_req_valid/ready/addr     one-word request to instruction memory
//   imem_rsp_valid/data           single-cycle response pulse with the word
//   inst_valid/ready              instruction handoff to the decoder
//   inst_out, inst_pc             held instruction and its PC
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. imem_req_valid is never withdrawn before imem_req_ready;
// inst_valid stays high with stable data until inst_ready or a redirect.
// At most one memory request is outstanding.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = INST_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
);

    fetch_state_e      state_d,      state_q;
    logic              kill_d,       kill_q;
    logic              req_valid_d,  req_valid_q;
    logic              inst_valid_d, inst_valid_q;
    logic [INST_W-1:0] inst_out_d,   inst_out_q;
    logic [ADDR_W-1:0] inst_pc_d,    inst_pc_q;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    ifu_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .load_pc (redirect_pc),
        .inc_en  (pc_inc),
        .pc      (pc)
    );

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        req_valid_d  = req_valid_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        case (state_q)
            S_IDLE: begin
                pc_load     = redirect_valid;
                state_d     = S_REQ;
                req_valid_d = 1'b1;
            end
            S_REQ: begin
                // The address may still move: the request is not yet accepted.
                pc_load = redirect_valid;
                if (imem_req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                    // Redirect on the accepting edge: the word in flight is stale.
                    kill_d      = redirect_valid;
                end
            end
            S_WAIT: begin
                pc_load = redirect_valid;
                if (imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_valid) begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                    end else begin
                        inst_out_d   = imem_rsp_data;
                        inst_pc_d    = pc;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Consumed or squashed: either way move on to the next fetch.
                if (inst_ready || redirect_valid) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                    req_valid_d  = 1'b1;
                    pc_load      = redirect_valid;
                    pc_inc       = ~redirect_valid;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign inst_valid     = inst_valid_q;
    assign inst_out       = inst_out_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: bench for ifu_fetch. The bench plays instruction memory
// (random acceptance and response delay) and the decoder, and checks the DUT
// every cycle against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory contents: 0x80000000 holds 0x00000013 (addi x0,x0,0).
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h8000_0013;
    endfunction

    // Reference model of the fetch stream.
    logic        m_out;        // a request is accepted and unanswered
    logic [63:0] m_out_pc;
    logic        m_kill;       // that request was overtaken by a redirect
    logic        m_held;       // an instruction is offered to the decoder
    logic [63:0] m_held_pc;
    logic [63:0] m_next_pc;    // address the next request must carry
    int          delivered;
    logic [63:0] exp_q[$];     // PCs of live requests awaiting delivery

    task automatic model_reset();
        m_out = 1'b0; m_kill = 1'b0; m_held = 1'b0;
        m_next_pc = RST_PC;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        logic old_out;
        logic old_held;
        // compare this cycle's outputs with the model
        check_eq("req_valid", imem_req_valid, !m_out && !m_held);
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, m_next_pc);
        check_eq("inst_valid", inst_valid, m_held);
        if (inst_valid && m_held) begin
            check_eq("inst_pc", inst_pc, m_held_pc);
            check_eq("inst_out", inst_out, mem_word(m_held_pc));
        end
        // advance the model by this cycle's inputs
        old_out  = m_out;
        old_held = m_held;
        if (old_out && imem_rsp_valid) begin
            if (!m_kill && !redirect_valid) begin
                m_held    = 1'b1;
                m_held_pc = exp_q.pop_front();
            end else begin
                void'(exp_q.pop_front());
            end
            m_out = 1'b0;
        end else if (old_out && redirect_valid) begin
            m_kill = 1'b1;
        end
        if (imem_req_valid && imem_req_ready) begin
            m_out  = 1'b1;
            m_kill = redirect_valid;
            exp_q.push_back(imem_req_addr);
        end
        if (old_held) begin
            if (inst_ready) begin
                delivered++;
                m_held    = 1'b0;
                m_next_pc = m_held_pc + 64'd4;
            end else if (redirect_valid) begin
                m_held = 1'b0;
            end
        end
        if (redirect_valid) m_next_pc = {redirect_pc[63:2], 2'b00};
    endtask

    // ---------------- drivers ----------------
    logic        drv_redirect = 1'b0;
    logic [63:0] drv_redirect_pc = '0;
    logic        drv_req_ready = 1'b1;
    logic        drv_inst_ready = 1'b0;
    int          drv_delay = 1;
    logic        mem_pending = 1'b0;
    logic [63:0] mem_addr = '0;
    int          mem_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        imem_req_ready = drv_req_ready;
        inst_ready     = drv_inst_ready;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pending    = 1'b0;
            end
        end
        @(negedge clk);
        model_cycle();
        if (imem_req_valid && imem_req_ready) begin
            mem_pending = 1'b1;
            mem_addr    = imem_req_addr;
            mem_cnt     = drv_delay;
        end
    endtask

    task automatic wait_inst(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!inst_valid && n < 20);
        if (!inst_valid) check_eq(tag, 64'd0, 64'd1);
    endtask

    task automatic redirect_once(input logic [63:0] target);
        drv_redirect    = 1'b1;
        drv_redirect_pc = target;
        tick();
        drv_redirect    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, imem_req_valid, 1'b0);
        check_eq({tag, "_req_addr"}, imem_req_addr, RST_PC);
        check_eq({tag, "_inst_valid"}, inst_valid, 1'b0);
        check_eq({tag, "_inst_out"}, inst_out, 64'd0);
        check_eq({tag, "_inst_pc"}, inst_pc, 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] hold_out;
        logic [63:0] hold_pc;
        int          rand_start;

        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; delivered = 0;
        model_reset();
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // first fetch, ready tied high, next-cycle response
        tick();
        check_eq("first_req_valid", imem_req_valid, 1'b1);
        check_eq("first_req_addr", imem_req_addr, 64'h8000_0000);
        wait_inst("first_inst_timeout");
        check_eq("first_inst_out", inst_out, 64'h0000_0013);
        check_eq("first_inst_pc", inst_pc, 64'h8000_0000);

        // consume; next request is sequential
        drv_inst_ready = 1'b1;
        tick();
        drv_inst_ready = 1'b0;
        drv_delay = 2;
        tick();
        check_eq("seq_inst_valid_low", inst_valid, 1'b0);
        check_eq("seq_req_addr", imem_req_addr, 64'h8000_0004);

        // redirect while waiting: response dropped, target re-aligned
        redirect_once(64'h8000_1002);
        tick();
        drv_delay = 1;
        tick();
        check_eq("wait_redir_inst_valid", inst_valid, 1'b0);
        check_eq("wait_redir_req_valid", imem_req_valid, 1'b1);
        check_eq("wait_redir_addr", imem_req_addr, 64'h8000_1000);
        wait_inst("wait_redir_timeout");
        check_eq("wait_redir_inst_pc", inst_pc, 64'h8000_1000);
        drv_inst_ready = 1'b1;
        tick();
        drv_inst_ready = 1'b0;

        // redirect on the request handshake edge
        redirect_once(64'h8000_2000);
        check_eq("hs_redir_req_valid", imem_req_valid, 1'b1);
        check_eq("hs_redir_req_addr", imem_req_addr, 64'h8000_1004);
        tick();
        tick();
        check_eq("hs_redir_reissue", imem_req_addr, 64'h8000_2000);
        wait_inst("hs_redir_timeout");
        check_eq("hs_redir_inst_pc", inst_pc, 64'h8000_2000);

        // decoder stalls: instruction stable, no new request
        hold_out = inst_out;
        hold_pc  = inst_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_out", inst_out, hold_out);
            check_eq("hold_pc", inst_pc, hold_pc);
            check_eq("hold_no_req", imem_req_valid, 1'b0);
        end
        redirect_once(64'h8000_3000);
        tick();
        check_eq("squash_inst_valid", inst_valid, 1'b0);
        check_eq("squash_req_addr", imem_req_addr, 64'h8000_3000);

        // wrap of the PC at the top of the address space
        redirect_once(64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check_eq("wrap_top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_inst("wrap_timeout");
        drv_inst_ready = 1'b1;
        tick();
        drv_inst_ready = 1'b0;
        drv_delay = 2;
        tick();
        check_eq("wrap_zero_addr", imem_req_addr, 64'd0);

        // asynchronous reset in the middle of a wait; stale response follows
        tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        drv_delay = 1;
        tick();
        check_eq("post_rst_stale_seen", imem_rsp_valid, 1'b1);
        check_eq("post_rst_addr", imem_req_addr, 64'h8000_0000);
        wait_inst("post_rst_timeout");
        check_eq("post_rst_inst_out", inst_out, 64'h0000_0013);
        check_eq("post_rst_inst_pc", inst_pc, 64'h8000_0000);

        // randomized traffic
        rand_start = delivered;
        for (int i = 0; i < 1500; i++) begin
            drv_req_ready   = ($urandom_range(0, 3) != 0);
            drv_inst_ready  = ($urandom_range(0, 2) == 0);
            drv_delay       = $urandom_range(1, 3);
            drv_redirect    = ($urandom_range(0, 9) == 0);
            drv_redirect_pc = ($urandom_range(0, 7) == 0) ?
                              {32'hFFFF_FFFF, 16'hFFFF, 16'($urandom)} :
                              {32'h0, 16'h8000, 16'($urandom)};
            tick();
        end
        drv_redirect = 1'b0;
        check_eq("rand_progress", (delivered - rand_start) >= 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
